// File: rtl/execute_stage_md.sv
// RV32 execute stage: ALU, operand forwarding, branch compare, JALR target, optional M-extension.
// Define EXEC_MULDIV_EN to build the single-cycle multiplier and the iterative radix-2 divider.
module execute_stage_md #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            ValidE,
   input  logic            FlushE,
   input  logic [1:0]      ForwardAE,
   input  logic [1:0]      ForwardBE,
   input  logic [XLEN-1:0] RD1E,
   input  logic [XLEN-1:0] RD2E,
   input  logic [XLEN-1:0] ExtImmE,
   input  logic [XLEN-1:0] PCE,
   input  logic [XLEN-1:0] ALUResultM,
   input  logic [XLEN-1:0] ResultW,
   input  logic            ALUSrcE,
   input  logic [4:0]      ALUControlE,
   input  logic            BranchE,
   input  logic            JumpE,
   input  logic            JalrE,
   input  logic [2:0]      Funct3E,
   output logic [XLEN-1:0] ALUResultE,
   output logic [XLEN-1:0] WriteDataE,
   output logic [XLEN-1:0] PCTargetE,
   output logic            PCSrcE,
   output logic            StallE
);

   localparam int SHW = $clog2(XLEN);

   logic [XLEN-1:0] src_a;
   logic [XLEN-1:0] fwd_b;
   logic [XLEN-1:0] src_b;
   logic [XLEN-1:0] alu_res;
   logic [XLEN-1:0] mul_res;
   logic [XLEN-1:0] div_res;
   logic [XLEN-1:0] jalr_sum;
   logic [SHW-1:0]  shamt;
   logic            div_done;
   logic            br_cond;
   logic            a_eq;
   logic            a_lt;
   logic            a_ltu;

   always_comb begin
      case (ForwardAE)
         2'b01:   src_a = ResultW;
         2'b10:   src_a = ALUResultM;
         default: src_a = RD1E;
      endcase
      case (ForwardBE)
         2'b01:   fwd_b = ResultW;
         2'b10:   fwd_b = ALUResultM;
         default: fwd_b = RD2E;
      endcase
   end

   assign src_b      = ALUSrcE ? ExtImmE : fwd_b;
   assign WriteDataE = fwd_b;
   assign shamt      = src_b[SHW-1:0];

   always_comb begin
      alu_res = '0;
      case (ALUControlE)
         5'b00000: alu_res = src_a + src_b;
         5'b00001: alu_res = src_a - src_b;
         5'b00010: alu_res = src_a & src_b;
         5'b00011: alu_res = src_a | src_b;
         5'b00100: alu_res = src_a ^ src_b;
         5'b00101: alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
         5'b00110: alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
         5'b00111: alu_res = src_a << shamt;
         5'b01000: alu_res = src_a >> shamt;
         5'b01001: alu_res = $unsigned($signed(src_a) >>> shamt);
         5'b01010: alu_res = src_b;
         default:  alu_res = '0;
      endcase
   end

   // Branches compare against forwarded B, never the immediate-muxed operand.
   assign a_eq  = (src_a == fwd_b);
   assign a_lt  = ($signed(src_a) < $signed(fwd_b));
   assign a_ltu = (src_a < fwd_b);

   always_comb begin
      br_cond = 1'b0;
      case (Funct3E)
         3'b000:  br_cond = a_eq;
         3'b001:  br_cond = ~a_eq;
         3'b100:  br_cond = a_lt;
         3'b101:  br_cond = ~a_lt;
         3'b110:  br_cond = a_ltu;
         3'b111:  br_cond = ~a_ltu;
         default: br_cond = 1'b0;
      endcase
   end

   assign PCSrcE    = ValidE & (JumpE | (BranchE & br_cond));
   assign jalr_sum  = src_a + ExtImmE;
   assign PCTargetE = JalrE ? {jalr_sum[XLEN-1:1], 1'b0} : (PCE + ExtImmE);

   assign ALUResultE = div_done ? div_res : (ALUControlE[4] ? mul_res : alu_res);

`ifdef EXEC_MULDIV_EN
   // state  | meaning
   // S_IDLE | no divide in flight; a valid divide op starts on the next edge
   // S_CALC | one quotient bit per cycle, cnt_q counts XLEN-1 down to 0
   // S_DONE | result presented on ALUResultE for one cycle
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [SHW-1:0] CNT_INIT = SHW'(XLEN - 1);
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]        state_q, state_d;
   logic [SHW-1:0]    cnt_q, cnt_d;
   logic [XLEN-1:0]   quo_q, quo_d;
   logic [XLEN-1:0]   rem_q, rem_d;
   logic [XLEN-1:0]   dvs_q, dvs_d;
   logic [XLEN-1:0]   dvd_q, dvd_d;
   logic              negq_q, negq_d;
   logic              negr_q, negr_d;
   logic              dz_q, dz_d;
   logic              ovf_q, ovf_d;
   logic              remop_q, remop_d;

   logic              is_div;
   logic              start;
   logic              signed_op;
   logic              a_neg;
   logic              b_neg;
   logic [XLEN-1:0]   a_mag;
   logic [XLEN-1:0]   b_mag;
   logic [XLEN:0]     shifted;
   logic [XLEN:0]     diff;
   logic [XLEN-1:0]   q_val;
   logic [XLEN-1:0]   r_val;

   logic              mul_a_signed;
   logic              mul_b_signed;
   logic [2*XLEN+1:0] mul_a_w;
   logic [2*XLEN+1:0] mul_b_w;
   logic [2*XLEN+1:0] prod;
   logic              unused_prod;

   // Operands are sign- or zero-extended to 2*XLEN+2 bits so one multiplier covers all four variants.
   assign mul_a_signed = (ALUControlE[1:0] == 2'b01) | (ALUControlE[1:0] == 2'b10);
   assign mul_b_signed = (ALUControlE[1:0] == 2'b01);
   assign mul_a_w      = {{(XLEN+2){mul_a_signed & src_a[XLEN-1]}}, src_a};
   assign mul_b_w      = {{(XLEN+2){mul_b_signed & src_b[XLEN-1]}}, src_b};
   assign prod         = mul_a_w * mul_b_w;
   assign unused_prod  = &{1'b0, prod[2*XLEN+1:2*XLEN]};

   always_comb begin
      mul_res = '0;
      case (ALUControlE)
         5'b10000: mul_res = prod[XLEN-1:0];
         5'b10001,
         5'b10010,
         5'b10011: mul_res = prod[2*XLEN-1:XLEN];
         default:  mul_res = '0;
      endcase
   end

   assign is_div    = (ALUControlE[4:2] == 3'b101);
   assign start     = (state_q == S_IDLE) & ValidE & is_div & ~FlushE;
   assign signed_op = ~ALUControlE[0];
   assign a_neg     = signed_op & src_a[XLEN-1];
   assign b_neg     = signed_op & src_b[XLEN-1];
   assign a_mag     = a_neg ? (~src_a + 1'b1) : src_a;
   assign b_mag     = b_neg ? (~src_b + 1'b1) : src_b;
   assign shifted   = {rem_q, quo_q[XLEN-1]};
   assign diff      = shifted - {1'b0, dvs_q};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      dvd_d   = dvd_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      dz_d    = dz_q;
      ovf_d   = ovf_q;
      remop_d = remop_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_CALC;
               cnt_d   = CNT_INIT;
               quo_d   = a_mag;
               rem_d   = '0;
               dvs_d   = b_mag;
               dvd_d   = src_a;
               negq_d  = a_neg ^ b_neg;
               negr_d  = a_neg;
               dz_d    = (src_b == '0);
               ovf_d   = signed_op & (src_a == INT_MIN) & (src_b == '1);
               remop_d = ALUControlE[1];
            end
         end
         S_CALC: begin
            if (!diff[XLEN]) begin
               rem_d = diff[XLEN-1:0];
               quo_d = {quo_q[XLEN-2:0], 1'b1};
            end else begin
               rem_d = shifted[XLEN-1:0];
               quo_d = {quo_q[XLEN-2:0], 1'b0};
            end
            if (cnt_q == '0) begin
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (FlushE) begin
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
         dvd_q   <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         dz_q    <= 1'b0;
         ovf_q   <= 1'b0;
         remop_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dvs_q   <= dvs_d;
         dvd_q   <= dvd_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         dz_q    <= dz_d;
         ovf_q   <= ovf_d;
         remop_q <= remop_d;
      end
   end

   // Special cases override the magnitude result so latency stays fixed.
   always_comb begin
      q_val = negq_q ? (~quo_q + 1'b1) : quo_q;
      r_val = negr_q ? (~rem_q + 1'b1) : rem_q;
      if (dz_q) begin
         q_val = '1;
         r_val = dvd_q;
      end else if (ovf_q) begin
         q_val = dvd_q;
         r_val = '0;
      end
   end

   assign div_res  = remop_q ? r_val : q_val;
   assign div_done = (state_q == S_DONE);
   assign StallE   = start | (state_q == S_CALC);
`else
   logic unused_md;

   assign mul_res   = '0;
   assign div_res   = '0;
   assign div_done  = 1'b0;
   assign StallE    = 1'b0;
   assign unused_md = &{1'b0, clk, reset_n, FlushE};
`endif

endmodule

// File: tb/tb_execute_stage_md.sv
// Directed bench for execute_stage_md: combinational vector table plus divider/flush/reset sequences.
// Divider sequences are exercised when EXEC_MULDIV_EN is defined; otherwise M ops must read as 0.
module tb_execute_stage_md;

   localparam int XLEN = 32;
`ifdef EXEC_MULDIV_EN
   localparam bit MD = 1'b1;
`else
   localparam bit MD = 1'b0;
`endif

   localparam logic [4:0] OP_ADD = 5'b00000, OP_SUB = 5'b00001, OP_AND = 5'b00010,
                          OP_OR = 5'b00011, OP_XOR = 5'b00100, OP_SLT = 5'b00101,
                          OP_SLTU = 5'b00110, OP_SLL = 5'b00111, OP_SRL = 5'b01000,
                          OP_SRA = 5'b01001, OP_LUI = 5'b01010, OP_BAD = 5'b01011,
                          OP_MUL = 5'b10000, OP_MULH = 5'b10001, OP_MULHSU = 5'b10010,
                          OP_MULHU = 5'b10011, OP_DIV = 5'b10100, OP_DIVU = 5'b10101,
                          OP_REM = 5'b10110, OP_REMU = 5'b10111, OP_MBAD = 5'b11000;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            ValidE, FlushE, ALUSrcE, BranchE, JumpE, JalrE;
   logic [1:0]      ForwardAE, ForwardBE;
   logic [XLEN-1:0] RD1E, RD2E, ExtImmE, PCE, ALUResultM, ResultW;
   logic [4:0]      ALUControlE;
   logic [2:0]      Funct3E;
   logic [XLEN-1:0] ALUResultE, WriteDataE, PCTargetE;
   logic            PCSrcE, StallE;

   int checks = 0;
   int errors = 0;

   execute_stage_md #(.XLEN(XLEN)) dut (
      .clk(clk), .reset_n(reset_n), .ValidE(ValidE), .FlushE(FlushE),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .RD1E(RD1E), .RD2E(RD2E),
      .ExtImmE(ExtImmE), .PCE(PCE), .ALUResultM(ALUResultM), .ResultW(ResultW),
      .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .BranchE(BranchE), .JumpE(JumpE),
      .JalrE(JalrE), .Funct3E(Funct3E), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
      .PCTargetE(PCTargetE), .PCSrcE(PCSrcE), .StallE(StallE)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1);
   end

   typedef struct packed {
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [31:0] alum;
      logic [31:0] resw;
      logic        alusrc;
      logic [4:0]  ctl;
      logic        br;
      logic        jmp;
      logic        jalr;
      logic [2:0]  f3;
      logic        valid;
      logic [31:0] e_res;
      logic [31:0] e_wd;
      logic [31:0] e_tgt;
      logic        e_pcsrc;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %h required %h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      ValidE = 1'b0; FlushE = 1'b0; ALUSrcE = 1'b0; BranchE = 1'b0; JumpE = 1'b0;
      JalrE = 1'b0; ForwardAE = 2'b00; ForwardBE = 2'b00; RD1E = '0; RD2E = '0;
      ExtImmE = '0; PCE = '0; ALUResultM = '0; ResultW = '0; ALUControlE = OP_ADD;
      Funct3E = 3'b000;
   endtask

   task automatic set_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      ForwardAE = 2'b00; ForwardBE = 2'b00; ALUSrcE = 1'b0; BranchE = 1'b0;
      JumpE = 1'b0; JalrE = 1'b0; ALUControlE = op; RD1E = a; RD2E = b;
      ExtImmE = '0; ValidE = 1'b1; FlushE = 1'b0;
   endtask

   // Called just after a falling edge; returns in the DONE cycle with ValidE still high.
   task automatic run_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string nm);
      int n;
      set_div(op, a, b);
      #1;
      n = 0;
      while (StallE === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
         #1;
      end
      chk({nm, " stall cycles"}, 32'(n), 32'(XLEN + 1));
      chk({nm, " result"}, ALUResultE, exp);
      chk({nm, " pcsrc"}, {31'b0, PCSrcE}, 32'h0);
   endtask

   initial begin
      // fa fb rd1 rd2 imm pc alum resw alusrc ctl br jmp jalr f3 valid | res wd tgt pcsrc
      vecs.push_back('{2'd0, 2'd0, 32'h7, 32'h0, 32'h2, 32'h24, 32'h0, 32'h0, 1'b1, OP_ADD, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1,
                       32'h9, 32'h0, 32'h26, 1'b0});
      vecs.push_back('{2'd2, 2'd1, 32'h1, 32'h2, 32'h0, 32'h0, 32'hCC, 32'h58, 1'b0, OP_SUB, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1,
                       32'h74, 32'h58, 32'h0, 1'b0});
      vecs.push_back('{2'd0, 2'd0, 32'hFFFFFFFF, 32'h1, 32'h10, 32'h100, 32'h0, 32'h0, 1'b0, OP_SUB, 1'b1, 1'b0, 1'b0, 3'b100, 1'b1,
                       32'hFFFFFFFE, 32'h1, 32'h110, 1'b1});
      vecs.push_back('{2'd0, 2'd0, 32'hFFFFFFFF, 32'h1, 32'h10, 32'h100, 32'h0, 32'h0, 1'b0, OP_SUB, 1'b1, 1'b0, 1'b0, 3'b110, 1'b1,
                       32'hFFFFFFFE, 32'h1, 32'h110, 1'b0});
      vecs.push_back('{2'd0, 2'd0, 32'h1001, 32'h0, 32'h4, 32'h200, 32'h0, 32'h0, 1'b1, OP_ADD, 1'b0, 1'b1, 1'b1, 3'b000, 1'b1,
                       32'h1005, 32'h0, 32'h1004, 1'b1});
      vecs.push_back('{2'd0, 2'd0, 32'h5, 32'h5, 32'h9, 32'h40, 32'h0, 32'h0, 1'b1, OP_ADD, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1,
                       32'hE, 32'h5, 32'h49, 1'b1});
      vecs.push_back('{2'd0, 2'd0, 32'h5, 32'h5, 32'h9, 32'h40, 32'h0, 32'h0, 1'b1, OP_ADD, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0,
                       32'hE, 32'h5, 32'h49, 1'b0});
      vecs.push_back('{2'd0, 2'd0, 32'h5, 32'h5, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, OP_ADD, 1'b1, 1'b0, 1'b0, 3'b001, 1'b1,
                       32'hA, 32'h5, 32'h0, 1'b0});
      vecs.push_back('{2'd0, 2'd0, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, OP_AND, 1'b1, 1'b0, 1'b0, 3'b101, 1'b1,
                       32'hFFFFFFFE, 32'hFFFFFFFE, 32'h0, 1'b1});
      vecs.push_back('{2'd0, 2'd0, 32'h1, 32'h80000000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, OP_OR, 1'b1, 1'b0, 1'b0, 3'b111, 1'b1,
                       32'h80000001, 32'h80000000, 32'h0, 1'b0});
      vecs.push_back('{2'd0, 2'd0, 32'hF0F0, 32'hF0F0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, OP_XOR, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1,
                       32'h0, 32'hF0F0, 32'h0, 1'b0});
      vecs.push_back('{2'd0, 2'd0, 32'hF0F0, 32'h0FF0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, OP_XOR, 1'b1, 1'b0, 1'b0, 3'b011, 1'b1,
                       32'hFF00, 32'h0FF0, 32'h0, 1'b0});
      vecs.push_back('{2'd0, 2'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, OP_SLT, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1,
                       32'h1, 32'h1, 32'h0, 1'b0});
      vecs.push_back('{2'd0, 2'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, OP_SLTU, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1,
                       32'h0, 32'h1, 32'h0, 1'b0});
      vecs.push_back('{2'd0, 2'd0, 32'h1, 32'h0, 32'h23, 32'h0, 32'h0, 32'h0, 1'b1, OP_SLL, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1,
                       32'h8, 32'h0, 32'h23, 1'b0});
      vecs.push_back('{2'd0, 2'd0, 32'h80000000, 32'h0, 32'h4, 32'h0, 32'h0, 32'h0, 1'b1, OP_SRL, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1,
                       32'h08000000, 32'h0, 32'h4, 1'b0});
      vecs.push_back('{2'd0, 2'd0, 32'h80000000, 32'h0, 32'h4, 32'h0, 32'h0, 32'h0, 1'b1, OP_SRA, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1,
                       32'hF8000000, 32'h0, 32'h4, 1'b0});
      vecs.push_back('{2'd0, 2'd0, 32'h0, 32'h0, 32'h12345000, 32'h0, 32'h0, 32'h0, 1'b1, OP_LUI, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1,
                       32'h12345000, 32'h0, 32'h12345000, 1'b0});
      vecs.push_back('{2'd0, 2'd0, 32'h3, 32'h4, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, OP_BAD, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1,
                       32'h0, 32'h4, 32'h0, 1'b0});
      vecs.push_back('{2'd3, 2'd3, 32'hA, 32'h6, 32'h1, 32'h0, 32'h63, 32'h4D, 1'b1, OP_ADD, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1,
                       32'hB, 32'h6, 32'h1, 1'b0});
      vecs.push_back('{2'd0, 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, OP_MUL, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1,
                       MD ? 32'h1 : 32'h0, 32'hFFFFFFFF, 32'h0, 1'b0});
      vecs.push_back('{2'd0, 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, OP_MULH, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1,
                       32'h0, 32'hFFFFFFFF, 32'h0, 1'b0});
      vecs.push_back('{2'd0, 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, OP_MULHU, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1,
                       MD ? 32'hFFFFFFFE : 32'h0, 32'hFFFFFFFF, 32'h0, 1'b0});
      vecs.push_back('{2'd0, 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, OP_MULHSU, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1,
                       MD ? 32'hFFFFFFFF : 32'h0, 32'hFFFFFFFF, 32'h0, 1'b0});
      vecs.push_back('{2'd0, 2'd0, 32'h12345678, 32'h10, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, OP_MUL, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1,
                       MD ? 32'h23456780 : 32'h0, 32'h10, 32'h0, 1'b0});
      vecs.push_back('{2'd0, 2'd0, 32'h12345678, 32'h10, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, OP_MULHU, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1,
                       MD ? 32'h1 : 32'h0, 32'h10, 32'h0, 1'b0});
      vecs.push_back('{2'd0, 2'd0, 32'hFFFFFFFE, 32'h3, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, OP_MULH, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1,
                       MD ? 32'hFFFFFFFF : 32'h0, 32'h3, 32'h0, 1'b0});
      vecs.push_back('{2'd0, 2'd0, 32'h9, 32'h9, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, OP_MBAD, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1,
                       32'h0, 32'h9, 32'h0, 1'b0});

      idle_inputs();
      reset_n = 1'b0;
      #2;
      chk("reset stall", {31'b0, StallE}, 32'h0);
      chk("reset result", ALUResultE, 32'h0);
      repeat (2) @(negedge clk);
      #1;
      chk("reset stall held", {31'b0, StallE}, 32'h0);
      reset_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         ForwardAE = vecs[i].fa; ForwardBE = vecs[i].fb; RD1E = vecs[i].rd1; RD2E = vecs[i].rd2;
         ExtImmE = vecs[i].imm; PCE = vecs[i].pc; ALUResultM = vecs[i].alum; ResultW = vecs[i].resw;
         ALUSrcE = vecs[i].alusrc; ALUControlE = vecs[i].ctl; BranchE = vecs[i].br;
         JumpE = vecs[i].jmp; JalrE = vecs[i].jalr; Funct3E = vecs[i].f3; ValidE = vecs[i].valid;
         #1;
         chk($sformatf("v%0d result", i), ALUResultE, vecs[i].e_res);
         chk($sformatf("v%0d writedata", i), WriteDataE, vecs[i].e_wd);
         chk($sformatf("v%0d target", i), PCTargetE, vecs[i].e_tgt);
         chk($sformatf("v%0d pcsrc", i), {31'b0, PCSrcE}, {31'b0, vecs[i].e_pcsrc});
         chk($sformatf("v%0d stall", i), {31'b0, StallE}, 32'h0);
      end

`ifdef EXEC_MULDIV_EN
      @(negedge clk);
      run_div(OP_DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, "div -7/2");
      ValidE = 1'b0;
      @(negedge clk);
      #1;
      chk("after done stall", {31'b0, StallE}, 32'h0);

      @(negedge clk);
      run_div(OP_REM, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, "rem -7/2");
      // Back-to-back: the next divide starts in the cycle after DONE.
      @(negedge clk);
      run_div(OP_DIVU, 32'h5, 32'h0, 32'hFFFFFFFF, "divu 5/0");
      @(negedge clk);
      run_div(OP_REMU, 32'h5, 32'h0, 32'h5, "remu 5/0");
      @(negedge clk);
      run_div(OP_DIV, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFFF, "div -7/0");
      @(negedge clk);
      run_div(OP_REM, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, "rem -7/0");
      @(negedge clk);
      run_div(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div ovf");
      @(negedge clk);
      run_div(OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'h0, "rem ovf");
      @(negedge clk);
      run_div(OP_DIV, 32'd100, 32'd7, 32'd14, "div 100/7");
      @(negedge clk);
      run_div(OP_REM, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, "rem -7/-2");
      ValidE = 1'b0;

      // Flush 10 cycles into a divide.
      @(negedge clk);
      set_div(OP_DIV, 32'd100, 32'd7);
      #1;
      chk("flush start stall", {31'b0, StallE}, 32'h1);
      repeat (10) @(negedge clk);
      #1;
      chk("flush calc stall", {31'b0, StallE}, 32'h1);
      FlushE = 1'b1;
      ValidE = 1'b0;
      @(negedge clk);
      #1;
      chk("flush idle stall", {31'b0, StallE}, 32'h0);
      chk("flush result dropped", ALUResultE, 32'h0);
      FlushE = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("flush stays idle", {31'b0, StallE}, 32'h0);

      // Asynchronous reset mid-CALC.
      @(negedge clk);
      set_div(OP_DIVU, 32'd1000, 32'd3);
      repeat (5) @(negedge clk);
      #1;
      chk("reset calc stall", {31'b0, StallE}, 32'h1);
      ValidE = 1'b0;
      reset_n = 1'b0;
      #1;
      chk("reset async stall", {31'b0, StallE}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("reset released stall", {31'b0, StallE}, 32'h0);
      @(negedge clk);
      run_div(OP_DIVU, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, "divu after reset");
      ValidE = 1'b0;
`else
      @(negedge clk);
      set_div(OP_DIV, 32'hFFFFFFF9, 32'h2);
      for (int c = 0; c < 4; c++) begin
         #1;
         chk($sformatf("nomd div stall c%0d", c), {31'b0, StallE}, 32'h0);
         chk($sformatf("nomd div result c%0d", c), ALUResultE, 32'h0);
         @(negedge clk);
      end
      ValidE = 1'b0;
`endif

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
